// File: rtl/tile_packer.sv
// Packs a 16-word stream into a 4x4 tile and writes it to tile memory in one cycle.
// Optional TILE_PACKER_AUTOINC_EN: after each write, keep filling at base+16 while it still fits.
module tile_packer #(
    parameter int unsigned MAX_BASE = 85
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  base_addr,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] t11, t12, t13, t14,
    output logic [31:0] t21, t22, t23, t24,
    output logic [31:0] t31, t32, t33, t34,
    output logic [31:0] t41, t42, t43, t44,
    output logic [7:0]  mem_addr,
    output logic        mem_write,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    // Compared 9 bits wide so base+16 cannot wrap past the limit.
    localparam logic [8:0] MAX9 = 9'(MAX_BASE);

    state_t            state;
    logic [3:0]        cnt;
    logic [15:0][31:0] tile;

    assign t11 = tile[0];  assign t12 = tile[1];  assign t13 = tile[2];  assign t14 = tile[3];
    assign t21 = tile[4];  assign t22 = tile[5];  assign t23 = tile[6];  assign t24 = tile[7];
    assign t31 = tile[8];  assign t32 = tile[9];  assign t33 = tile[10]; assign t34 = tile[11];
    assign t41 = tile[12]; assign t42 = tile[13]; assign t43 = tile[14]; assign t44 = tile[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_addr  <= '0;
            tile      <= '0;
            in_ready  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err       <= 1'b0;
            done      <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if ({1'b0, base_addr} <= MAX9) begin
                            mem_addr <= base_addr;
                            cnt      <= '0;
                            state    <= FILL;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        tile[cnt] <= in_data;
                        cnt       <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state     <= WRITE;
                            in_ready  <= 1'b0;
                            mem_write <= 1'b1;
                        end
                    end
                end
                WRITE: begin
`ifdef TILE_PACKER_AUTOINC_EN
                    if ({1'b0, mem_addr} + 9'd16 <= MAX9) begin
                        mem_addr <= mem_addr + 8'd16;
                        state    <= FILL;
                        in_ready <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
`else
                    state <= DONE;
                    done  <= 1'b1;
`endif
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tile_packer.md
TILE_PACKER -- requirements
Module: tile_packer

Interface
REQ-001 Parameter: MAX_BASE, default 85, highest legal tile base address (base+15 must stay within the 101-word tile memory).
REQ-002 Port: clk  input  1  rising-edge clock, the only clock.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  one-cycle request to begin packing at base_addr.
REQ-005 Port: base_addr  input  8  tile base word address, sampled on an accepted start.
REQ-006 Port: in_data  input  32  incoming word stream.
REQ-007 Port: in_valid  input  1  in_data valid.
REQ-008 Port: in_ready  output  1  packer accepts a word this cycle.
REQ-009 Port: t11..t44  output  32 each (16 ports)  assembled tile; connect one-to-one to the tile memory i11..i44.
REQ-010 Port: mem_addr  output  8  tile memory address.
REQ-011 Port: mem_write  output  1  tile memory write strobe.
REQ-012 Port: busy  output  1  high in any state other than IDLE.
REQ-013 Port: done  output  1  one-cycle pulse after the last tile write.
REQ-014 Port: err  output  1  one-cycle pulse when start is rejected for an out-of-range base.

Function
REQ-015 FSM states: IDLE, FILL, WRITE, DONE; 4-bit beat counter cnt.
REQ-016 IDLE + start + base_addr<=MAX_BASE: latch base_addr into mem_addr; clear cnt; next state FILL.
REQ-017 IDLE + start + base_addr>MAX_BASE: err=1 next cycle for one cycle; stay IDLE; mem_addr unchanged.
REQ-018 start in any state other than IDLE: ignored, with no err.
REQ-019 in_ready=1 only in FILL; 0 in all other states.
REQ-020 Beat: in_valid&in_ready; word stored row-major by cnt (0->t11, 1->t12, 3->t14, 4->t21, ... 15->t44); cnt increments.
REQ-021 in_valid low in FILL: no change; gaps of any length allowed.
REQ-022 Beat with cnt==15: cnt wraps to 0; next state WRITE.
REQ-023 WRITE lasts exactly one cycle: mem_write=1, mem_addr=latched base, t11..t44 stable.
REQ-024 mem_write=0 in all states except WRITE.
REQ-025 The block never drives a memory read; the memory read input is tied 0 at integration.
REQ-026 Latency: mem_write is high in the cycle immediately after the 16th accepted beat.
REQ-027 DONE lasts one cycle with done=1, then goes to IDLE (see REQ-035 for the burst variant).
REQ-028 t11..t44 hold their values after the write until overwritten by later beats.

Reset
REQ-029 rst sampled high at a clock edge: state=IDLE, cnt=0, mem_addr=0, t11..t44=0, in_ready=0, mem_write=0, busy=0, done=0, err=0.
REQ-030 rst during FILL or WRITE: the partial tile is discarded; no mem_write pulse is issued during or after reset.
REQ-031 rst has priority over start and in_valid in the same cycle.

Configuration
REQ-032 Macro: TILE_PACKER_AUTOINC_EN.
REQ-033 Without the macro: one start packs exactly one tile (16 beats), then one write, then one done.
REQ-034 With the macro, in WRITE: if mem_addr+16<=MAX_BASE, mem_addr+=16 and the next state is FILL without a new start, and done is not pulsed.
REQ-035 With the macro, in WRITE: if mem_addr+16>MAX_BASE, the next state is DONE, so the burst ends with a single done pulse.
REQ-036 With the macro, the arithmetic is 8-bit; the compare is computed 9 bits wide so it cannot wrap.

Verification
REQ-037 Case 1: rst, then start with base_addr=0, then 16 beats of words 1..16 -> mem_write one cycle after beat 16 with mem_addr=0, t11=1, t14=4, t21=5, t44=16; done one cycle later.
REQ-038 Case 2: start with base_addr=86 -> err pulses once, busy stays 0, no mem_write.
REQ-039 Case 3: in_valid toggled every other cycle during FILL -> same tile contents as case 1; write occurs after the 16th accepted beat.
REQ-040 Case 4: rst asserted after beat 9 -> all outputs 0; no mem_write; a following clean fill packs correctly.
REQ-041 Case 5: start pulsed during FILL -> ignored; mem_addr unchanged.
REQ-042 Case 6 (TILE_PACKER_AUTOINC_EN): start with base_addr=48 and 48 beats -> writes at addresses 48, 64, 80; done after the third write; in_ready=0 after it.
